ahb_lite_master: RTL and testbench

//  AHB-Lite initiator: turns a simple valid/ready command stream into single (NONSEQ, HBURST=SINGLE) bus transfers.

---
 rtl/ahb_pkg.sv | 32 +++
 rtl/ahb_lite_master.sv | 154 +++++++++++++++
 tb/tb_ahb_lite_master.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// ============================================================================
// ahb_pkg : shared AHB-Lite encodings and master FSM state type
// Revision: 1.0
// ============================================================================
`default_nettype none

package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HSIZE_DWORD   = 3'b011;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_ERR2 = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ahb_lite_master.sv
// ============================================================================
// ahb_lite_master : valid/ready command stream to pipelined AHB-Lite SINGLE transfers
// Revision: 1.0
// ============================================================================
`default_nettype none

module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [2:0]    cmd_size,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  output logic          rsp_err,
  output logic [DW-1:0] rsp_rdata,
  output logic [AW-1:0] HADDR,
  output logic [1:0]    HTRANS,
  output logic          HWRITE,
  output logic [2:0]    HSIZE,
  output logic [2:0]    HBURST,
  output logic [3:0]    HPROT,
  output logic [DW-1:0] HWDATA,
  input  logic          HREADY,
  input  logic          HRESP,
  input  logic [DW-1:0] HRDATA
);

  state_t        r_state;
  logic          r_rdy_en;
  logic          r_a_vld;
  logic [DW-1:0] r_a_wdata;
  logic          r_d_vld;
  logic          r_d_write;
  logic          r_rp_vld;
  logic          r_rp_write;
  logic [AW-1:0] r_rp_addr;
  logic [2:0]    r_rp_size;
  logic [DW-1:0] r_rp_wdata;

  logic          w_accept;
  logic          w_err1;

  // The address slot itself is HADDR/HWRITE/HSIZE; r_a_vld says whether it is live.
  assign cmd_ready = (~r_a_vld | HREADY) & (r_state == ST_RUN) & r_rdy_en & ~HRESET;
  assign w_accept  = cmd_valid & cmd_ready;
  assign w_err1    = (r_state == ST_RUN) & r_d_vld & ~HREADY & (HRESP == HRESP_ERROR);

  assign HBURST = HBURST_SINGLE;
  assign HPROT  = HPROT_DEFAULT;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state    <= ST_RUN;
      r_rdy_en   <= 1'b0;
      r_a_vld    <= 1'b0;
      r_a_wdata  <= '0;
      r_d_vld    <= 1'b0;
      r_d_write  <= 1'b0;
      r_rp_vld   <= 1'b0;
      r_rp_write <= 1'b0;
      r_rp_addr  <= '0;
      r_rp_size  <= '0;
      r_rp_wdata <= '0;
      HADDR      <= '0;
      HTRANS     <= HTRANS_IDLE;
      HWRITE     <= 1'b0;
      HSIZE      <= '0;
      HWDATA     <= '0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      r_rdy_en  <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;

      if (r_state == ST_RUN) begin
        if (w_err1) begin
          // First ERROR cycle: park whatever owns the address slot for replay.
          r_state <= ST_ERR2;
          r_a_vld <= 1'b0;
          HTRANS  <= HTRANS_IDLE;
          if (r_a_vld) begin
            r_rp_vld   <= 1'b1;
            r_rp_write <= HWRITE;
            r_rp_addr  <= HADDR;
            r_rp_size  <= HSIZE;
            r_rp_wdata <= r_a_wdata;
          end else if (w_accept) begin
            r_rp_vld   <= 1'b1;
            r_rp_write <= cmd_write;
            r_rp_addr  <= cmd_addr;
            r_rp_size  <= cmd_size;
            r_rp_wdata <= cmd_wdata;
          end
        end else begin
          if (HREADY) begin
            if (r_d_vld) begin
              rsp_valid <= 1'b1;
              rsp_err   <= HRESP;
              rsp_rdata <= (~r_d_write & (HRESP == HRESP_OKAY)) ? HRDATA : '0;
            end
            r_d_vld <= r_a_vld;
            if (r_a_vld) begin
              r_d_write <= HWRITE;
              HWDATA    <= r_a_wdata;
            end
          end

          if (w_accept) begin
            r_a_vld   <= 1'b1;
            HTRANS    <= HTRANS_NONSEQ;
            HADDR     <= cmd_addr;
            HWRITE    <= cmd_write;
            HSIZE     <= cmd_size;
            r_a_wdata <= cmd_wdata;
          end else if (HREADY) begin
            r_a_vld <= 1'b0;
            HTRANS  <= HTRANS_IDLE;
          end
        end
      end else begin
        // Second ERROR cycle; OKAY here is a slave violation and still ends in error.
        if (HREADY) begin
          r_state   <= ST_RUN;
          r_d_vld   <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
          if (r_rp_vld) begin
            r_rp_vld  <= 1'b0;
            r_a_vld   <= 1'b1;
            HTRANS    <= HTRANS_NONSEQ;
            HADDR     <= r_rp_addr;
            HWRITE    <= r_rp_write;
            HSIZE     <= r_rp_size;
            r_a_wdata <= r_rp_wdata;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ahb_lite_master.sv
// ============================================================================
// tb_ahb_lite_master : directed and randomized checks of ahb_lite_master
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ahb_lite_master;
  import ahb_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [2:0]  cmd_size = HSIZE_WORD;
  logic [31:0] cmd_wdata = '0;
  logic        cmd_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  int n_cmp  = 0;
  int n_fail = 0;
  int wait_cfg = 0;

  // slave model: 256-word memory, region 0xF... answers with a two-cycle ERROR
  logic [31:0] smem [256];
  logic        dp_vld = 1'b0, dp_write = 1'b0, dp_err = 1'b0, err_ph = 1'b0;
  logic [31:0] dp_addr = '0, dp_rdata = '0;
  int          dp_wait = 0;

  // reference model: same word-indexed memory view plus expected {err, rdata} stream
  logic [31:0] ref_mem [256];
  logic [32:0] exp_q [$];

  always #5 HCLK = ~HCLK;

  ahb_lite_master #(.AW(32), .DW(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  always @* begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = 32'hBAD0_BAD0;
    if (dp_vld) begin
      if (dp_wait != 0) HREADY = 1'b0;
      else if (dp_err) begin
        HRESP  = 1'b1;
        HREADY = err_ph;
      end else if (!dp_write) HRDATA = dp_rdata;
    end
  end

  always @(posedge HCLK) begin
    if (HRESET) begin
      dp_vld <= 1'b0;
      err_ph <= 1'b0;
      for (int i = 0; i < 256; i++) smem[i] = 32'hC0DE_0000 | i;
    end else begin
      if (dp_vld) begin
        if (dp_wait != 0) dp_wait <= dp_wait - 1;
        else if (dp_err && !err_ph) err_ph <= 1'b1;
        else begin
          dp_vld <= 1'b0;
          err_ph <= 1'b0;
          if (dp_write && !dp_err) smem[dp_addr[9:2]] = HWDATA;
        end
      end
      if (HREADY && HTRANS == HTRANS_NONSEQ) begin
        dp_vld   <= 1'b1;
        dp_addr  <= HADDR;
        dp_write <= HWRITE;
        dp_err   <= (HADDR[31:28] == 4'hF);
        err_ph   <= 1'b0;
        dp_wait  <= (wait_cfg < 0) ? int'($urandom_range(0, 2)) : wait_cfg;
        dp_rdata <= smem[HADDR[9:2]];
      end
    end
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    cmd_valid = 1'b0;
    wait_cfg = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({HTRANS, rsp_valid, cmd_ready} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_ctl[%0d]: got htrans/rsp_valid/cmd_ready=%b want 0000", i, {HTRANS, rsp_valid, cmd_ready});
      end
    end
    n_cmp++;
    if ({HADDR, HWRITE, HSIZE, HWDATA, rsp_err, rsp_rdata, HBURST, HPROT} !==
        {32'h0, 1'b0, 3'h0, 32'h0, 1'b0, 32'h0, 3'h0, 4'h3}) begin
      n_fail++;
      $display("FAIL reset_bus: got haddr=%h hwrite=%b hsize=%h hwdata=%h err=%b rdata=%h hburst=%h hprot=%h want zeros, hprot=3",
               HADDR, HWRITE, HSIZE, HWDATA, rsp_err, rsp_rdata, HBURST, HPROT);
    end
    HRESET = 1'b0;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_after_reset_1: got %b want 0", cmd_ready);
    end
    tick();
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset_2: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_write_read();
    wait_cfg = 0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h2000_0004;
    cmd_size = HSIZE_WORD; cmd_wdata = 32'hDEAD_BEEF;
    tick();
    n_cmp++;
    if ({HTRANS, HADDR, HWRITE, cmd_ready} !== {HTRANS_NONSEQ, 32'h2000_0004, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL wr_addr_phase: got htrans=%b haddr=%h hwrite=%b ready=%b want 10/20000004/1/1", HTRANS, HADDR, HWRITE, cmd_ready);
    end
    cmd_write = 1'b0;
    tick();
    cmd_valid = 1'b0;
    n_cmp++;
    if ({HTRANS, HADDR, HWRITE, HWDATA} !== {HTRANS_NONSEQ, 32'h2000_0004, 1'b0, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL rd_addr_wr_data: got htrans=%b haddr=%h hwrite=%b hwdata=%h want 10/20000004/0/deadbeef", HTRANS, HADDR, HWRITE, HWDATA);
    end
    tick();
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_rdata, HTRANS} !== {1'b1, 1'b0, 32'h0, HTRANS_IDLE}) begin
      n_fail++;
      $display("FAIL wr_rsp: got valid=%b err=%b rdata=%h htrans=%b want 1/0/0/00", rsp_valid, rsp_err, rsp_rdata, HTRANS);
    end
    tick();
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL rd_rsp: got valid=%b err=%b rdata=%h want 1/0/deadbeef", rsp_valid, rsp_err, rsp_rdata);
    end
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_rd_quiet: got rsp_valid=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_wait_states();
    int cnt = 0;
    wait_cfg = 3;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0100; cmd_size = HSIZE_WORD;
    tick();
    cmd_write = 1'b1; cmd_addr = 32'h0000_0200; cmd_wdata = 32'h1111_1111;
    tick();
    cmd_addr = 32'h0000_0300; cmd_wdata = 32'h3333_3333;
    wait_cfg = 0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({HTRANS, HADDR, HWRITE, cmd_ready, rsp_valid} !== {HTRANS_NONSEQ, 32'h200, 1'b1, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL wait_hold[%0d]: got htrans=%b haddr=%h hwrite=%b ready=%b rsp=%b want 10/200/1/0/0",
                 i, HTRANS, HADDR, HWRITE, cmd_ready, rsp_valid);
      end
      tick();
    end
    n_cmp++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL wait_last: got rsp=%b ready=%b want 0/1", rsp_valid, cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_rdata, HWDATA} !== {1'b1, 1'b0, 32'hC0DE_0040, 32'h1111_1111}) begin
      n_fail++;
      $display("FAIL wait_rsp: got valid=%b err=%b rdata=%h hwdata=%h want 1/0/c0de0040/11111111",
               rsp_valid, rsp_err, rsp_rdata, HWDATA);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid === 1'b1) cnt++;
    end
    n_cmp++;
    if (cnt != 2) begin
      n_fail++;
      $display("FAIL wait_drain: got %0d responses want 2", cnt);
    end
  endtask

  task automatic test_error();
    wait_cfg = 0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'hF000_0000; cmd_size = HSIZE_WORD;
    tick();
    cmd_write = 1'b1; cmd_addr = 32'h0000_0010; cmd_wdata = 32'hA5A5_0010;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL err_queue_ready: got %b want 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    n_cmp++;
    if ({HTRANS, HADDR, cmd_ready, rsp_valid} !== {HTRANS_NONSEQ, 32'h10, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL err_cycle1: got htrans=%b haddr=%h ready=%b rsp=%b want 10/10/0/0", HTRANS, HADDR, cmd_ready, rsp_valid);
    end
    tick();
    n_cmp++;
    if ({HTRANS, rsp_valid, cmd_ready} !== {HTRANS_IDLE, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL err_cycle2: got htrans=%b rsp=%b ready=%b want 00/0/0", HTRANS, rsp_valid, cmd_ready);
    end
    tick();
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_rdata, HTRANS, HADDR, HWRITE} !==
        {1'b1, 1'b1, 32'h0, HTRANS_NONSEQ, 32'h10, 1'b1}) begin
      n_fail++;
      $display("FAIL err_rsp_replay: got valid=%b err=%b rdata=%h htrans=%b haddr=%h hwrite=%b want 1/1/0/10/10/1",
               rsp_valid, rsp_err, rsp_rdata, HTRANS, HADDR, HWRITE);
    end
    tick();
    n_cmp++;
    if ({HWDATA, rsp_valid} !== {32'hA5A5_0010, 1'b0}) begin
      n_fail++;
      $display("FAIL replay_data: got hwdata=%h rsp=%b want a5a50010/0", HWDATA, rsp_valid);
    end
    tick();
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL replay_rsp: got valid=%b err=%b rdata=%h want 1/0/0", rsp_valid, rsp_err, rsp_rdata);
    end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0010;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'hA5A5_0010}) begin
      n_fail++;
      $display("FAIL replay_readback: got valid=%b err=%b rdata=%h want 1/0/a5a50010", rsp_valid, rsp_err, rsp_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int cnt = 0;
    wait_cfg = 5;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0100; cmd_size = HSIZE_WORD;
    tick();
    cmd_valid = 1'b0;
    tick();
    HRESET = 1'b1;
    tick();
    n_cmp++;
    if ({HTRANS, HADDR, HWRITE, HSIZE, HWDATA, rsp_valid, cmd_ready} !==
        {HTRANS_IDLE, 32'h0, 1'b0, 3'h0, 32'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset_bus: got htrans=%b haddr=%h hwrite=%b hsize=%h hwdata=%h rsp=%b ready=%b want all 0",
               HTRANS, HADDR, HWRITE, HSIZE, HWDATA, rsp_valid, cmd_ready);
    end
    tick();
    HRESET = 1'b0;
    wait_cfg = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rsp_valid === 1'b1) cnt++;
    end
    n_cmp++;
    if (cnt != 0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_after: got %0d responses ready=%b want 0 responses ready=1", cnt, cmd_ready);
    end
  endtask

  task automatic test_stream();
    int got = 0;
    logic [32:0] e;
    logic [31:0] a;
    wait_cfg = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'hC0DE_0000 | i;
    for (int k = 0; k < 22; k++) begin
      if (rsp_valid === 1'b1) begin
        got++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL stream_extra_rsp: got rdata=%h want no response", rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          if ({rsp_err, rsp_rdata} !== e) begin
            n_fail++;
            $display("FAIL stream_rsp: got err=%b rdata=%h want err=%b rdata=%h", rsp_err, rsp_rdata, e[32], e[31:0]);
          end
        end
      end
      if (k >= 1 && k <= 16) begin
        a = 32'h4000 + 32'((k - 1) * 4);
        n_cmp++;
        if ({HTRANS, HADDR} !== {HTRANS_NONSEQ, a}) begin
          n_fail++;
          $display("FAIL stream_nonseq[%0d]: got htrans=%b haddr=%h want 10/%h", k, HTRANS, HADDR, a);
        end
      end
      if (k == 17) begin
        n_cmp++;
        if (HTRANS !== HTRANS_IDLE) begin
          n_fail++;
          $display("FAIL stream_end_idle: got htrans=%b want 00", HTRANS);
        end
      end
      if (k < 16) begin
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_size = HSIZE_WORD;
        cmd_addr = 32'h4000 + 32'(k * 4);
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_ready[%0d]: got %b want 1", k, cmd_ready);
        end
        exp_q.push_back({1'b0, ref_mem[cmd_addr[9:2]]});
      end else begin
        cmd_valid = 1'b0;
      end
      tick();
    end
    n_cmp++;
    if (got != 16 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stream_count: got %0d responses (%0d outstanding) want 16 (0)", got, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    int sent = 0, got = 0, cyc = 0;
    bit acc = 1'b0;
    logic [32:0] e;
    logic [7:0] idx;
    wait_cfg = -1;
    cmd_valid = 1'b0;
    while (got < 200 && cyc < 4000) begin
      if (acc) begin
        cmd_valid = 1'b0;
        acc = 1'b0;
      end
      if (rsp_valid === 1'b1) begin
        got++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL random_extra_rsp: got err=%b rdata=%h want no response", rsp_err, rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          if ({rsp_err, rsp_rdata} !== e) begin
            n_fail++;
            $display("FAIL random_rsp[%0d]: got err=%b rdata=%h want err=%b rdata=%h", got, rsp_err, rsp_rdata, e[32], e[31:0]);
          end
        end
      end
      if (!cmd_valid && sent < 200 && $urandom_range(0, 3) != 0) begin
        cmd_valid = 1'b1;
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr  = (($urandom_range(0, 7) == 0) ? 32'hF000_0000 : 32'h0000_1000) | (32'($urandom_range(0, 15)) << 2);
        cmd_wdata = $urandom;
        cmd_size  = HSIZE_WORD;
      end
      if (cmd_valid && cmd_ready === 1'b1) begin
        acc = 1'b1;
        sent++;
        idx = cmd_addr[9:2];
        if (cmd_addr[31:28] == 4'hF) exp_q.push_back({1'b1, 32'h0});
        else if (cmd_write) begin
          ref_mem[idx] = cmd_wdata;
          exp_q.push_back({1'b0, 32'h0});
        end else exp_q.push_back({1'b0, ref_mem[idx]});
      end
      tick();
      cyc++;
    end
    cmd_valid = 1'b0;
    n_cmp++;
    if (got != 200 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL random_count: got %0d responses (%0d outstanding) want 200 (0)", got, exp_q.size());
    end
    wait_cfg = 0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wait_states();
    test_error();
    test_reset_mid();
    test_stream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion want completion within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
